clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
- Power-up and reset sequencer clocked by the PLL's fast output (60 MHz, from the 27 MHz board oscillator).
- Filters and synchronizes the PLL lock indication and waits a settle time.
- Releases the system reset, then releases per-stage resets in a staggered order.
- Generates a divided clock-enable strobe for logic in the main domain, and detects and counts lock loss.

Parameters:
- SETTLE_CYCLES, 6000: cycles to wait after lock is qualified (100 us at 60 MHz).
- LOCK_FILTER, 8: consecutive synchronized lock-high cycles required to qualify lock.
- NUM_STAGES, 3: number of staggered stage reset outputs (1..8).
- STAGE_GAP, 16: cycles between successive stage reset releases (≥1).
- CE_DIV, 2: ce strobe period in cycles (≥1); a value of 2 gives a 30 MHz enable.
- HB_DIV, 30000000: half-period of the heartbeat output in cycles (used only with the optional feature).

Ports:
- clk  in  1  PLL fast clock output.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock; asynchronous to clk; tie 1 if the PLL does not expose lock.
- soft_rst  in  1  synchronous single-cycle request to restart the sequence.
- sys_rst_n  out  1  registered active-low system reset.
- stage_rst_n  out  NUM_STAGES  registered active-low stage resets.
- ready  out  1  high while in RUN.
- ce  out  1  single-cycle enable strobe, every CE_DIV cycles while ready.
- lock_loss_cnt  out  8  saturating count of lock-loss events.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset: one clock domain. rst_n is asynchronous, active-low and overrides everything.
- Outputs under rst_n low:
  - sys_rst_n=0, stage_rst_n=all 0, ready=0, ce=0.
  - lock_loss_cnt=0, state=RESET(0), all internal counters 0.
- All outputs are registered.
- Lock synchronization: pll_lock passes through a 2-FF synchronizer to give lock_s (2-cycle latency).
- Priority, highest first: rst_n, soft_rst, lock loss, normal progression.
- States:
  - RESET(0): all resets asserted. Goes to WAIT_LOCK on the next edge.
  - WAIT_LOCK(1): counts consecutive lock_s=1 cycles; any lock_s=0 clears the count. When the count reaches LOCK_FILTER, goes to SETTLE with the settle counter at 0.
  - SETTLE(2): counts to SETTLE_CYCLES. lock_s=0 for any cycle returns to WAIT_LOCK; this is not counted as a loss. On count reaching SETTLE_CYCLES, goes to RELEASE.
  - RELEASE(3):
    - sys_rst_n goes 1 on the edge entering RELEASE.
    - stage_rst_n[i] goes 1 exactly STAGE_GAP*(i+1) cycles after sys_rst_n rises.
    - Goes to RUN on the same edge that releases stage NUM_STAGES-1.
  - RUN(4): ready=1, all resets deasserted.
  - FAULT(5): entered from RELEASE or RUN when lock_s=0 for 2 consecutive cycles.
    - On entry: sys_rst_n=0, stage_rst_n=0, ready=0 (same edge).
    - lock_loss_cnt increments by 1 and saturates at 255.
    - Stays exactly 1 cycle, then goes to WAIT_LOCK.
- Single-cycle lock glitch in RELEASE/RUN: ignored.
- soft_rst=1 in any state: goes to RESET on the next edge.
  - All resets are asserted on that edge and ready=0.
  - lock_loss_cnt is unchanged.
  - soft_rst has priority over a simultaneous lock loss, so no increment occurs.
- ce divider:
  - Counter is held at 0 while ready=0.
  - While ready=1 the counter runs 0..CE_DIV-1, and ce=1 during the cycle where counter==CE_DIV-1.
  - The first ce occurs CE_DIV cycles after ready rises.
  - With CE_DIV=1, ce=ready.
  - ce drops on the same edge that ready drops.
- Counter widths are sized with $clog2 of their parameter. No wrap occurs before the terminal count in any state.

Optional Feature:
- Macro: CLK_RST_SEQUENCER_HEARTBEAT_EN.
- When defined:
  - Adds output port heartbeat (1 bit), reset value 0.
  - heartbeat toggles every HB_DIV cycles while ready=1, and is forced to 0 while ready=0.
- When undefined: the port and its counter are absent, and behaviour is otherwise identical.

Test Plan:
- Bench parameters: SETTLE_CYCLES=20, LOCK_FILTER=4, STAGE_GAP=3, NUM_STAGES=3, CE_DIV=2.
- Cold start: pll_lock=1, release rst_n -> state 0→1→2, with SETTLE entered 4 cycles after lock_s rises. sys_rst_n rises 20 cycles after SETTLE entry. stage_rst_n[0..2] rise +3/+6/+9 cycles after that. ready rises with stage 2. First ce is 2 cycles after ready, then every 2nd cycle.
- Lock chatter: pll_lock high 3 cycles, low 1, repeated -> stays in WAIT_LOCK. sys_rst_n stays 0 and lock_loss_cnt stays 0.
- Settle abort: drop pll_lock for 1 cycle at settle count 10 -> returns to WAIT_LOCK. A full 4+20 cycles are needed after lock recovers, and lock_loss_cnt stays 0.
- Lock loss in RUN:
  - 1-cycle low pulse -> no change.
  - 2-cycle low -> FAULT for 1 cycle, all resets 0, ready=0, ce=0, lock_loss_cnt=1, then a full re-sequence.
  - Repeating 256 times -> lock_loss_cnt holds at 255.
- Soft reset: soft_rst pulse in RUN, on the same cycle as the 2nd lock-low cycle -> state=0 next edge, resets asserted, lock_loss_cnt unchanged.
- Async reset mid-RELEASE: rst_n low after stage 0 is released -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_rst_sequencer.sv
// Power-up / reset sequencer: qualifies PLL lock, waits a settle time, then releases
// system and staggered stage resets. Optional heartbeat output: CLK_RST_SEQUENCER_HEARTBEAT_EN.
module clk_rst_sequencer #(
    parameter int SETTLE_CYCLES = 6000,
    parameter int LOCK_FILTER   = 8,
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_GAP     = 16,
    parameter int CE_DIV        = 2,
    parameter int HB_DIV        = 30000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  soft_rst,
    output logic                  sys_rst_n,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic                  ce,
    output logic [7:0]            lock_loss_cnt,
    output logic [2:0]            state
`ifdef CLK_RST_SEQUENCER_HEARTBEAT_EN
    ,
    output logic                  heartbeat
`endif
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    localparam int FILT_W  = $clog2(LOCK_FILTER + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int REL_MAX = STAGE_GAP * NUM_STAGES;
    localparam int REL_W   = $clog2(REL_MAX + 1);
    localparam int CE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(REL_MAX - 1);
    localparam logic [CE_W-1:0]   CE_LAST   = CE_W'(CE_DIV - 1);

    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 8 || STAGE_GAP < 1 || CE_DIV < 1 ||
            LOCK_FILTER < 1 || SETTLE_CYCLES < 1 || HB_DIV < 1) begin : g_bad_param
            $error("clk_rst_sequencer: parameter out of range");
        end
    endgenerate

    logic [1:0]            sync_q;
    logic                  low_q, low_d;
    state_t                state_q, state_d;
    logic [FILT_W-1:0]     filt_q, filt_d;
    logic [SET_W-1:0]      settle_q, settle_d;
    logic [REL_W-1:0]      rel_q, rel_d;
    logic [CE_W-1:0]       ce_cnt_q, ce_cnt_d;
    logic                  sys_q, sys_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic                  ce_q, ce_d;
    logic [7:0]            loss_q, loss_d;
    logic                  lock_s, lock_lost;

    assign lock_s    = sync_q[1];
    // Two consecutive synchronized low cycles count as a real loss; one is a glitch.
    assign lock_lost = ~lock_s & low_q;
    assign low_d     = ~lock_s;

    always_comb begin
        state_d  = state_q;
        filt_d   = filt_q;
        settle_d = settle_q;
        rel_d    = rel_q;
        sys_d    = sys_q;
        stage_d  = stage_q;
        ready_d  = ready_q;
        loss_d   = loss_q;

        if (soft_rst) begin
            state_d  = S_RESET;
            filt_d   = '0;
            settle_d = '0;
            rel_d    = '0;
            sys_d    = 1'b0;
            stage_d  = '0;
            ready_d  = 1'b0;
        end else if (lock_lost && (state_q == S_RELEASE || state_q == S_RUN)) begin
            state_d = S_FAULT;
            rel_d   = '0;
            sys_d   = 1'b0;
            stage_d = '0;
            ready_d = 1'b0;
            if (loss_q != 8'hFF)
                loss_d = loss_q + 8'd1;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_d  = S_WAIT_LOCK;
                    filt_d   = '0;
                    settle_d = '0;
                    rel_d    = '0;
                    sys_d    = 1'b0;
                    stage_d  = '0;
                    ready_d  = 1'b0;
                end
                S_WAIT_LOCK: begin
                    settle_d = '0;
                    if (!lock_s) begin
                        filt_d = '0;
                    end else if (filt_q == FILT_LAST) begin
                        filt_d  = '0;
                        state_d = S_SETTLE;
                    end else begin
                        filt_d = filt_q + FILT_W'(1);
                    end
                end
                S_SETTLE: begin
                    // A lock drop here is a retry, not a counted loss.
                    if (!lock_s) begin
                        state_d  = S_WAIT_LOCK;
                        settle_d = '0;
                        filt_d   = '0;
                    end else if (settle_q == SET_LAST) begin
                        state_d  = S_RELEASE;
                        settle_d = '0;
                        rel_d    = '0;
                        sys_d    = 1'b1;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                S_RELEASE: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (rel_q == REL_W'(STAGE_GAP * (i + 1) - 1))
                            stage_d[i] = 1'b1;
                    end
                    if (rel_q == REL_LAST) begin
                        state_d = S_RUN;
                        rel_d   = '0;
                        ready_d = 1'b1;
                    end else begin
                        rel_d = rel_q + REL_W'(1);
                    end
                end
                S_RUN: begin
                    ready_d = 1'b1;
                end
                S_FAULT: begin
                    state_d = S_WAIT_LOCK;
                    filt_d  = '0;
                end
                default: begin
                    state_d = S_RESET;
                end
            endcase
        end
    end

    // The divider only advances once ready was already high, so the first strobe lands CE_DIV cycles after ready.
    always_comb begin
        ce_cnt_d = '0;
        ce_d     = 1'b0;
        if (ready_d && ready_q) begin
            ce_cnt_d = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + CE_W'(1);
            ce_d     = (ce_cnt_q == CE_LAST);
        end
        if (CE_DIV == 1)
            ce_d = ready_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            low_q    <= 1'b0;
            state_q  <= S_RESET;
            filt_q   <= '0;
            settle_q <= '0;
            rel_q    <= '0;
            ce_cnt_q <= '0;
            sys_q    <= 1'b0;
            stage_q  <= '0;
            ready_q  <= 1'b0;
            ce_q     <= 1'b0;
            loss_q   <= '0;
        end else begin
            sync_q   <= {sync_q[0], pll_lock};
            low_q    <= low_d;
            state_q  <= state_d;
            filt_q   <= filt_d;
            settle_q <= settle_d;
            rel_q    <= rel_d;
            ce_cnt_q <= ce_cnt_d;
            sys_q    <= sys_d;
            stage_q  <= stage_d;
            ready_q  <= ready_d;
            ce_q     <= ce_d;
            loss_q   <= loss_d;
        end
    end

`ifdef CLK_RST_SEQUENCER_HEARTBEAT_EN
    localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_DIV - 1);

    logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
    logic            hb_q, hb_d;

    always_comb begin
        hb_cnt_d = '0;
        hb_d     = 1'b0;
        if (ready_d && ready_q) begin
            hb_cnt_d = (hb_cnt_q == HB_LAST) ? '0 : hb_cnt_q + HB_W'(1);
            hb_d     = (hb_cnt_q == HB_LAST) ? ~hb_q : hb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign heartbeat = hb_q;
`endif

    assign sys_rst_n     = sys_q;
    assign stage_rst_n   = stage_q;
    assign ready         = ready_q;
    assign ce            = ce_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: expected event times/values are queued as
// stimulus is applied, then popped and compared against what the DUT produced.
module tb_clk_rst_sequencer;

    localparam int SETTLE = 20;
    localparam int LF     = 4;
    localparam int GAP    = 3;
    localparam int NS     = 3;
    localparam int CED    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          soft_rst = 1'b0;
    logic          sys_rst_n;
    logic [NS-1:0] stage_rst_n;
    logic          ready;
    logic          ce;
    logic [7:0]    lock_loss_cnt;
    logic [2:0]    state;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string name;
        int    want;
    } exp_t;

    exp_t expq[$];
    int   got[string];

    clk_rst_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .LOCK_FILTER  (LF),
        .NUM_STAGES   (NS),
        .STAGE_GAP    (GAP),
        .CE_DIV       (CED),
        .HB_DIV       (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock     (pll_lock),
        .soft_rst     (soft_rst),
        .sys_rst_n    (sys_rst_n),
        .stage_rst_n  (stage_rst_n),
        .ready        (ready),
        .ce           (ce),
        .lock_loss_cnt(lock_loss_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input string n, input int w);
        exp_t e;
        e.name = n;
        e.want = w;
        expq.push_back(e);
    endtask

    // Hard reset with lock present, then run until ready (bounded).
    task automatic bring_up();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        soft_rst = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 100 && ready !== 1'b1; k++) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bring_up_ready: got %b expected 1", ready);
        end
    endtask

    // Two synchronized lock-low cycles starting at the current negedge; returns at the negedge after the fault edge.
    task automatic lock_drop2();
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t e;
        got.delete();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        push_exp("rst_sys", 0);
        push_exp("rst_stage", 0);
        push_exp("rst_ready", 0);
        push_exp("rst_ce", 0);
        push_exp("rst_cnt", 0);
        push_exp("rst_state", 0);
        got["rst_sys"]   = int'(sys_rst_n);
        got["rst_stage"] = int'(stage_rst_n);
        got["rst_ready"] = int'(ready);
        got["rst_ce"]    = int'(ce);
        got["rst_cnt"]   = int'(lock_loss_cnt);
        got["rst_state"] = int'(state);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_cold_start();
        exp_t e;
        int   c0, r;
        got.delete();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        // Edge numbers relative to reset release: lock_s rises at 2, SETTLE 4 later.
        push_exp("cs_wait_lock", 1);
        push_exp("cs_settle", 6);
        push_exp("cs_sys_rst", 26);
        push_exp("cs_stage0", 29);
        push_exp("cs_stage1", 32);
        push_exp("cs_stage2", 35);
        push_exp("cs_ready", 35);
        push_exp("cs_run_state", 35);
        push_exp("cs_ce_first", 37);
        push_exp("cs_ce_at38", 0);
        push_exp("cs_ce_second", 39);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            r = cyc - c0;
            if (state == 3'd1 && !got.exists("cs_wait_lock")) got["cs_wait_lock"] = r;
            if (state == 3'd2 && !got.exists("cs_settle"))    got["cs_settle"] = r;
            if (sys_rst_n && !got.exists("cs_sys_rst"))       got["cs_sys_rst"] = r;
            if (stage_rst_n[0] && !got.exists("cs_stage0"))   got["cs_stage0"] = r;
            if (stage_rst_n[1] && !got.exists("cs_stage1"))   got["cs_stage1"] = r;
            if (stage_rst_n[2] && !got.exists("cs_stage2"))   got["cs_stage2"] = r;
            if (ready && !got.exists("cs_ready"))             got["cs_ready"] = r;
            if (state == 3'd4 && !got.exists("cs_run_state")) got["cs_run_state"] = r;
            if (r == 38) got["cs_ce_at38"] = int'(ce);
            if (ce === 1'b1) begin
                if (!got.exists("cs_ce_first")) got["cs_ce_first"] = r;
                else if (!got.exists("cs_ce_second")) got["cs_ce_second"] = r;
            end
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_lock_chatter();
        exp_t e;
        int   max_state, sys_ever;
        got.delete();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        max_state = 0;
        sys_ever = 0;
        push_exp("ch_max_state", 1);
        push_exp("ch_sys_ever", 0);
        push_exp("ch_loss", 0);
        push_exp("ch_recover_settle", 1);
        for (int k = 0; k < 40; k++) begin
            pll_lock = ((k % 4) != 3);
            @(negedge clk);
            if (int'(state) > max_state) max_state = int'(state);
            if (sys_rst_n === 1'b1) sys_ever = 1;
        end
        got["ch_max_state"] = max_state;
        got["ch_sys_ever"] = sys_ever;
        got["ch_loss"] = int'(lock_loss_cnt);
        pll_lock = 1'b1;
        got["ch_recover_settle"] = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (state == 3'd2) got["ch_recover_settle"] = 1;
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_settle_abort();
        exp_t e;
        int   s0, r;
        got.delete();
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30 && state !== 3'd2; k++) @(negedge clk);
        s0 = cyc;
        repeat (10) @(negedge clk);
        // Settle count is 10 here; a one-cycle drop reaches lock_s two edges later.
        pll_lock = 1'b0;
        push_exp("sa_back_to_wait", 13);
        push_exp("sa_resettle", 17);
        push_exp("sa_release", 37);
        push_exp("sa_loss", 0);
        @(negedge clk);
        pll_lock = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            r = cyc - s0;
            if (state == 3'd1 && !got.exists("sa_back_to_wait")) got["sa_back_to_wait"] = r;
            if (state == 3'd2 && got.exists("sa_back_to_wait") && !got.exists("sa_resettle")) got["sa_resettle"] = r;
            if (state == 3'd3 && !got.exists("sa_release")) got["sa_release"] = r;
        end
        got["sa_loss"] = int'(lock_loss_cnt);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_lock_loss_run();
        exp_t e;
        int   v0, r, disturbed;
        got.delete();
        bring_up();
        push_exp("ll_glitch_disturb", 0);
        push_exp("ll_glitch_loss", 0);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        disturbed = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (state !== 3'd4 || ready !== 1'b1) disturbed = 1;
        end
        got["ll_glitch_disturb"] = disturbed;
        got["ll_glitch_loss"] = int'(lock_loss_cnt);

        v0 = cyc;
        push_exp("ll_fault_state", 5);
        push_exp("ll_fault_sys", 0);
        push_exp("ll_fault_stage", 0);
        push_exp("ll_fault_ready", 0);
        push_exp("ll_fault_ce", 0);
        push_exp("ll_fault_cnt", 1);
        push_exp("ll_after_fault_state", 1);
        push_exp("ll_resettle", 9);
        push_exp("ll_reready", 38);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            r = cyc - v0;
            if (r == 4) begin
                got["ll_fault_state"] = int'(state);
                got["ll_fault_sys"]   = int'(sys_rst_n);
                got["ll_fault_stage"] = int'(stage_rst_n);
                got["ll_fault_ready"] = int'(ready);
                got["ll_fault_ce"]    = int'(ce);
                got["ll_fault_cnt"]   = int'(lock_loss_cnt);
            end
            if (r == 5) got["ll_after_fault_state"] = int'(state);
            if (r > 5 && state == 3'd2 && !got.exists("ll_resettle")) got["ll_resettle"] = r;
            if (r > 5 && ready === 1'b1 && !got.exists("ll_reready")) got["ll_reready"] = r;
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_soft_reset();
        exp_t e;
        got.delete();
        bring_up();
        lock_drop2();
        for (int k = 0; k < 60 && ready !== 1'b1; k++) @(negedge clk);
        push_exp("sr_pre_cnt", 1);
        push_exp("sr_state", 0);
        push_exp("sr_sys", 0);
        push_exp("sr_stage", 0);
        push_exp("sr_ready", 0);
        push_exp("sr_ce", 0);
        push_exp("sr_cnt", 1);
        push_exp("sr_next_state", 1);
        got["sr_pre_cnt"] = int'(lock_loss_cnt);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        @(negedge clk);
        // Second lock-low cycle: soft_rst must win over the loss.
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        got["sr_state"] = int'(state);
        got["sr_sys"]   = int'(sys_rst_n);
        got["sr_stage"] = int'(stage_rst_n);
        got["sr_ready"] = int'(ready);
        got["sr_ce"]    = int'(ce);
        got["sr_cnt"]   = int'(lock_loss_cnt);
        @(negedge clk);
        got["sr_next_state"] = int'(state);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        got.delete();
        bring_up();
        lock_drop2();
        for (int k = 0; k < 60 && stage_rst_n[0] !== 1'b1; k++) @(negedge clk);
        push_exp("ar_pre_state", 3);
        push_exp("ar_pre_cnt", 1);
        push_exp("ar_sys", 0);
        push_exp("ar_stage", 0);
        push_exp("ar_ready", 0);
        push_exp("ar_ce", 0);
        push_exp("ar_cnt", 0);
        push_exp("ar_state", 0);
        got["ar_pre_state"] = int'(state);
        got["ar_pre_cnt"] = int'(lock_loss_cnt);
        #2;
        rst_n = 1'b0;
        #1;
        got["ar_sys"]   = int'(sys_rst_n);
        got["ar_stage"] = int'(stage_rst_n);
        got["ar_ready"] = int'(ready);
        got["ar_ce"]    = int'(ce);
        got["ar_cnt"]   = int'(lock_loss_cnt);
        got["ar_state"] = int'(state);
        @(negedge clk);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    task automatic test_loss_saturation();
        exp_t e;
        int   timeouts;
        got.delete();
        bring_up();
        timeouts = 0;
        push_exp("sat_cnt_1", 1);
        push_exp("sat_cnt_254", 254);
        push_exp("sat_cnt_255", 255);
        push_exp("sat_cnt_256", 255);
        push_exp("sat_timeouts", 0);
        for (int i = 1; i <= 256 && timeouts == 0; i++) begin
            for (int k = 0; k < 80 && ready !== 1'b1; k++) @(negedge clk);
            if (ready !== 1'b1) timeouts++;
            lock_drop2();
            if (i == 1)   got["sat_cnt_1"]   = int'(lock_loss_cnt);
            if (i == 254) got["sat_cnt_254"] = int'(lock_loss_cnt);
            if (i == 255) got["sat_cnt_255"] = int'(lock_loss_cnt);
            if (i == 256) got["sat_cnt_256"] = int'(lock_loss_cnt);
        end
        got["sat_timeouts"] = timeouts;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (!got.exists(e.name) || got[e.name] !== e.want) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got.exists(e.name) ? got[e.name] : -1, e.want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_lock_chatter();
        test_settle_abort();
        test_lock_loss_run();
        test_soft_reset();
        test_async_reset();
        test_loss_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
